// File: rtl/seq_frame_arbiter.sv
// seq_frame_arbiter: round-robin share of one serial overlapping pattern matcher among N_REQ frame sources.
// Latency: grant at T, result strobe at T+FRAME_W+1; next grant no earlier than T+FRAME_W+2.
// Backpressure: req is a level; no grant is issued while a frame is in flight, waiting requests just stay pending.
module seq_frame_arbiter #(
  parameter int                N_REQ     = 4,
  parameter int                FRAME_W   = 16,
  parameter int                PAT_W     = 4,
  parameter int                CNT_W     = 5,
  parameter logic [PAT_W-1:0]  PAT_RESET = 4'b1011
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_W-1:0]   frame,
  output logic [N_REQ-1:0]           gnt,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pattern,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic [CNT_W-1:0]           res_count
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(FRAME_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // bit_cnt value at which the window first holds PAT_W frame bits
  localparam logic [BC_W-1:0] WIN_FULL   = BC_W'(PAT_W - 1);
  localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(FRAME_W - 1);
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(N_REQ - 1);

  logic [1:0]         state;
  logic [PAT_W-1:0]   pattern;
  logic [ID_W-1:0]    last_id;
  logic [FRAME_W-1:0] shreg;
  logic [PAT_W-1:0]   hist;
  logic [BC_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]   count;

  logic               any_req;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    idx;
  logic [PAT_W-1:0]   hist_nxt;
  logic               match;

  // Round-robin pick: first requesting id above last_id, wrapping around.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(last_id) + i) % N_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

  // History window after shifting in the current MSB; oldest bit ends up on top.
  assign hist_nxt = PAT_W'({hist, shreg[FRAME_W-1]});
  // Only count once the window is filled entirely with bits of this frame.
  assign match    = (bit_cnt >= WIN_FULL) && (hist_nxt == pattern);

  // Control FSM, serializer, matcher and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pattern   <= PAT_RESET;
      last_id   <= LAST_RESET;
      shreg     <= '0;
      hist      <= '0;
      bit_cnt   <= '0;
      count     <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      busy <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          // Pattern writes land before a same-cycle grant, so that frame sees the new pattern.
          if (cfg_we) pattern <= cfg_pattern;
          if (any_req) begin
            gnt     <= N_REQ'(1) << sel;
            shreg   <= frame[sel*FRAME_W +: FRAME_W];
            last_id <= sel;
            hist    <= '0;
            bit_cnt <= '0;
            count   <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg   <= shreg << 1;
          hist    <= hist_nxt;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (match && (count != '1)) count <= count + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state <= ST_DONE;
        end
        ST_DONE: begin
          done      <= 1'b1;
          res_id    <= last_id;
          res_count <= count;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_arbiter.sv
`timescale 1ns/1ps
// tb_seq_frame_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Latency: model predicts grant, busy window, done strobe and result per cycle.
// Backpressure: requesters hold req until they observe their grant (except the round-robin hold test).
module tb_seq_frame_arbiter;

  localparam int N_REQ   = 4;
  localparam int FRAME_W = 16;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 5;
  localparam int SAT_W   = 2;
  localparam logic [PAT_W-1:0] PAT_RESET = 4'b1011;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*FRAME_W-1:0] frame;
  logic                     cfg_we;
  logic [PAT_W-1:0]         cfg_pattern;
  logic [N_REQ-1:0]         gnt, sat_gnt;
  logic                     busy, done, sat_busy, sat_done;
  logic [1:0]               res_id, sat_res_id;
  logic [CNT_W-1:0]         res_count;
  logic [SAT_W-1:0]         sat_res_count;

  always #5 clk = ~clk;

  seq_frame_arbiter #(.N_REQ(N_REQ), .FRAME_W(FRAME_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_RESET(PAT_RESET)) u_dut (
    .clk(clk), .reset(reset), .req(req), .frame(frame), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .busy(busy), .done(done),
    .res_id(res_id), .res_count(res_count)
  );

  seq_frame_arbiter #(.N_REQ(N_REQ), .FRAME_W(FRAME_W), .PAT_W(PAT_W), .CNT_W(SAT_W), .PAT_RESET(PAT_RESET)) u_sat (
    .clk(clk), .reset(reset), .req(req), .frame(frame), .gnt(sat_gnt),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .busy(sat_busy), .done(sat_done),
    .res_id(sat_res_id), .res_count(sat_res_count)
  );

  int errors = 0;
  int checks = 0;

  // model state
  int               cyc = 0;
  int               m_last;
  logic [PAT_W-1:0] m_pat;
  int               m_g;
  int               m_next_free;
  int               m_pend_id, m_pend_raw;
  int               m_res_id, m_res_cnt;
  bit               auto_drop = 1'b1;
  int               last_done_cyc;
  int               done_q[$];
  int               id_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Number of MSB-first windows of the frame equal to the pattern.
  function automatic int count_matches(input logic [FRAME_W-1:0] f, input logic [PAT_W-1:0] p);
    int n = 0;
    for (int k = PAT_W - 1; k < FRAME_W; k++)
      if (((f >> (FRAME_W - 1 - k)) & ((1 << PAT_W) - 1)) == p) n++;
    return n;
  endfunction

  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] r);
    for (int i = 1; i <= N_REQ; i++)
      if (r[(last + i) % N_REQ]) return (last + i) % N_REQ;
    return -1;
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_reset();
    m_last      = N_REQ - 1;
    m_pat       = PAT_RESET;
    m_g         = -1000;
    m_next_free = 0;
    m_res_id    = 0;
    m_res_cnt   = 0;
  endtask

  // One clock: inputs as currently driven are sampled, then all outputs checked against the model.
  task automatic step();
    logic [N_REQ-1:0]         d_req;
    logic                     d_we;
    logic [PAT_W-1:0]         d_pat;
    logic [N_REQ*FRAME_W-1:0] d_frame;
    logic [N_REQ-1:0]         e_gnt;
    int                       s;
    d_req   = req;
    d_we    = cfg_we;
    d_pat   = cfg_pattern;
    d_frame = frame;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    e_gnt = '0;
    if (cyc >= m_next_free) begin
      if (d_we) m_pat = d_pat;
      if (d_req != '0) begin
        s           = rr_pick(m_last, d_req);
        e_gnt[s]    = 1'b1;
        m_last      = s;
        m_g         = cyc;
        m_next_free = cyc + FRAME_W + 2;
        m_pend_id   = s;
        m_pend_raw  = count_matches(d_frame[s*FRAME_W +: FRAME_W], m_pat);
      end
    end
    if (cyc == m_g + FRAME_W + 1) begin
      m_res_id  = m_pend_id;
      m_res_cnt = m_pend_raw;
    end
    chk("gnt", gnt, e_gnt);
    chk("busy", busy, (cyc > m_g) && (cyc <= m_g + FRAME_W + 1));
    chk("done", done, cyc == m_g + FRAME_W + 1);
    chk("res_id", res_id, m_res_id);
    chk("res_count", res_count, sat(m_res_cnt, (1 << CNT_W) - 1));
    chk("sat_res_count", sat_res_count, sat(m_res_cnt, (1 << SAT_W) - 1));
    chk("sat_done", sat_done, done);
    if (done) begin
      last_done_cyc = cyc;
      done_q.push_back(cyc);
      id_q.push_back(int'(res_id));
    end
    if (auto_drop) req = req & ~gnt;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (gnt == '0 && n < 40);
    if (gnt == '0) chk({tag, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!done && n < 40);
    if (!done) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_count"}, res_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [N_REQ*FRAME_W-1:0] frame0(input logic [FRAME_W-1:0] f);
    logic [N_REQ*FRAME_W-1:0] v = '0;
    v[FRAME_W-1:0] = f;
    return v;
  endfunction

  initial begin
    int g0;
    reset       = 1'b0;
    req         = '0;
    frame       = '0;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    #2;
    do_reset("rst");

    // overlapping matches of 1011 in B600
    req   = 4'b0001;
    frame = frame0(16'hB600);
    wait_gnt("ovl");
    g0 = cyc;
    chk("ovl_gnt", gnt, 4'b0001);
    wait_done("ovl");
    chk("ovl_latency", last_done_cyc - g0, 17);
    chk("ovl_id", res_id, 0);
    chk("ovl_cnt", res_count, 2);

    // round robin with all requests held
    do_reset("rst2");
    auto_drop = 1'b0;
    req   = 4'b1111;
    frame = {16'hF0F0, 16'h1234, 16'hB0B0, 16'hBBBB};
    done_q.delete();
    id_q.delete();
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr");
      chk("rr_order", gnt, 4'b0001 << (k % 4));
    end
    req       = '0;
    auto_drop = 1'b1;
    for (int n = 0; n < 60 && done_q.size() < 5; n++) step();
    chk("rr_done_count", done_q.size(), 5);
    if (done_q.size() >= 5) begin
      for (int i = 1; i < 5; i++) begin
        chk("rr_done_spacing", done_q[i] - done_q[i-1], 18);
        chk("rr_res_id", id_q[i-1], (i - 1) % 4);
      end
    end

    // window-fill boundary with pattern written in the grant cycle
    cfg_we      = 1'b1;
    cfg_pattern = 4'b0000;
    req         = 4'b0001;
    frame       = frame0(16'h0000);
    step();
    cfg_we = 1'b0;
    chk("wf_gnt", gnt, 4'b0001);
    wait_done("wf0");
    chk("wf_cnt_zero", res_count, 13);
    chk("sat_cnt", sat_res_count, 3);
    req   = 4'b0001;
    frame = frame0(16'h0FFF);
    wait_gnt("wf1");
    wait_done("wf1");
    chk("wf_cnt_0fff", res_count, 1);

    // config writes mid-frame are ignored
    cfg_we      = 1'b1;
    cfg_pattern = 4'b1011;
    step();
    cfg_we = 1'b0;
    req    = 4'b0001;
    frame  = frame0(16'hB000);
    wait_gnt("cg0");
    repeat (5) step();
    cfg_we      = 1'b1;
    cfg_pattern = 4'b1111;
    step();
    cfg_we = 1'b0;
    wait_done("cg0");
    chk("cg_cnt_b000", res_count, 1);
    req   = 4'b0001;
    frame = frame0(16'hF000);
    wait_gnt("cg1");
    wait_done("cg1");
    chk("cg_cnt_f000", res_count, 0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
        if ($urandom_range(0, 2) == 0)
          frame[i*FRAME_W +: FRAME_W] = {4{4'($urandom)}};
        else
          frame[i*FRAME_W +: FRAME_W] = 16'($urandom);
      end
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_pattern = 4'($urandom);
      step();
    end
    cfg_we = 1'b0;
    req    = '0;
    for (int n = 0; n < 20; n++) step();

    // reset in the middle of a frame
    req   = 4'b0001;
    frame = frame0(16'hB600);
    wait_gnt("rm");
    repeat (4) step();
    chk("rm_busy_before", busy, 1);
    req = 4'b0110;
    do_reset("rm");
    step();
    chk("rm_first_gnt", gnt, 4'b0010);
    for (int n = 0; n < 40; n++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
